imm_extend_queue: RTL
=====================

// Module: imm_extend_queue
// PURPOSE
//   Parametrised successor to the 8->16 immediate extender. Extends an IN_W-bit
//   immediate to OUT_W bits in one of four modes, then buffers results in a
//   DEPTH-entry FIFO with valid/ready handshakes on both sides.
//   Sits between instruction decode and the ALU operand mux. Absorbs ALU-side
//   stalls without dropping immediates.
// PARAMETERS
//   IN_W   8   immediate input width; 1 <= IN_W < OUT_W
//   OUT_W  16  extended output width
//   DEPTH  4   FIFO entries; power of two, 2..16
//   CNT_W  $clog2(DEPTH)+1  occupancy counter width (derived, not overridden)
// PORTS
//   clk        in   1      clock; all state changes on rising edge
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      in_data/in_mode are valid this cycle
//   in_ready   out  1      FIFO can accept an entry this cycle
//   in_data    in   IN_W   raw immediate
//   in_mode    in   2      00 zero-ext, 01 sign-ext, 10 place-high, 11 sign-ext<<1
//   out_valid  out  1      out_data holds the oldest unconsumed result
//   out_ready  in   1      consumer takes out_data this cycle
//   out_data   out  OUT_W  extended immediate (head of FIFO)
//   count      out  CNT_W  current occupancy, 0..DEPTH
// BEHAVIOUR
//   Extension (combinational, before FIFO write), E = OUT_W-IN_W:
//    - 00: {E'b0, in_data}
//    - 01: {{E{in_data[IN_W-1]}}, in_data}
//    - 10: {in_data, E'b0}; if E < IN_W, keep the low OUT_W bits of that vector
//    - 11: mode-01 result shifted left 1, LSB=0; MSB discarded (no saturation)
//   Handshake:
//    - push = in_valid & in_ready
//    - pop  = out_valid & out_ready
//    - in_ready = (count != DEPTH); registered/state-derived only, never
//      depends on out_ready (no comb path in->out)
//    - out_valid = (count != 0); out_data = mem[rd_ptr]; undefined-but-stable
//      when out_valid=0, never X after reset
//   Latency: push at edge N -> out_valid=1 from cycle N+1 if FIFO was empty.
//     No fall-through in the same cycle.
//   Pointers: wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
//     count tracks occupancy separately.
//   Simultaneous events:
//    - push & pop, 0<count<DEPTH: count unchanged, both pointers advance
//    - push & pop at count==0: impossible (out_valid=0), treated as push only
//    - at count==DEPTH: in_ready=0, so push=0 even if out_ready=1 that cycle;
//      the slot frees next cycle
//    - in_valid while in_ready=0: ignored, no state change; producer holds data
//   Reset (any cycle, incl. mid-burst):
//    - wr_ptr=rd_ptr=0, count=0, out_valid=0, in_ready=1
//    - storage contents need not clear; out_data is 0 while count==0
//    - in-flight entries are discarded
//   Consumer rule: out_data/out_valid stay stable while out_valid=1 and
//     out_ready=0.
// TESTING
//   1 IN_W=8,OUT_W=16: push 8'h85 in modes 00/01/10/11 -> out 16'h0085,
//     16'hFF85, 16'h8500, 16'hFF0A in order, each 1 cycle after push.
//   2 DEPTH=4, out_ready=0, push 6 with in_valid held -> exactly 4 accepted,
//     count=4, in_ready=0; then out_ready=1 -> 4 results in push order.
//   3 Full FIFO, in_valid=1 and out_ready=1 same cycle -> pop only, count=3;
//     next cycle push accepted, count=4.
//   4 count=2, continuous push+pop for 10 cycles -> count stays 2,
//     pointers wrap, data order preserved.
//   5 Assert reset with count=3 and in_valid=1 -> next cycle count=0,
//     out_valid=0, in_ready=1, out_data=0; the presented entry is not stored.
//   6 IN_W=4,OUT_W=6, mode 10 with 4'b1011 -> 6'b101100;
//     mode 11 with 4'b1000 -> 6'b110000.

Source files
------------

// File: rtl/imm_extend_queue.sv
// imm_extend_queue: extends an IN_W-bit immediate to OUT_W bits (4 modes) and queues it in a DEPTH-entry FIFO.
// Latency: a push at edge N is visible on out_data/out_valid from cycle N+1 (no same-cycle fall-through).
// Backpressure: in_ready depends only on occupancy (count != DEPTH); out_data holds while out_ready is low.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid/in_ready     producer handshake; in_data = raw immediate, in_mode = extension mode
//   out_valid/out_ready   consumer handshake; out_data = oldest extended immediate (0 when empty)
//   count                 occupancy, 0..DEPTH
module imm_extend_queue #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  localparam int E     = OUT_W - IN_W;
  localparam int PTR_W = $clog2(DEPTH);

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [OUT_W-1:0] zext_dat, sext_dat, high_dat, sext2_dat, ext_dat;
  logic             push, pop;

  // Extension happens before the FIFO write so the stored entry is final.
  always_comb begin
    zext_dat  = {{E{1'b0}}, in_data};
    sext_dat  = {{E{in_data[IN_W-1]}}, in_data};
    high_dat  = {in_data, {E{1'b0}}};
    // Mode 11: sign-extended value doubled; the MSB simply falls off.
    sext2_dat = {sext_dat[OUT_W-2:0], 1'b0};
    ext_dat   = zext_dat;
    case (in_mode)
      2'b00:   ext_dat = zext_dat;
      2'b01:   ext_dat = sext_dat;
      2'b10:   ext_dat = high_dat;
      default: ext_dat = sext2_dat;
    endcase
  end

  // Both flags are purely occupancy-derived, so there is no comb path from out_ready to in_ready.
  assign in_ready  = (cnt_q != CNT_W'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = cnt_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    // Pointers are log2(DEPTH) wide, so +1 wraps DEPTH-1 -> 0 naturally.
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not cleared; out_data is masked to 0 whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= ext_dat;
    end
  end

endmodule
